// File: rtl/mmio_pkg.sv
// Shared types and default widths for the two-master MMIO bus arbiter.
package mmio_pkg;

    localparam int MMIO_ADDR_W = 32;
    localparam int MMIO_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; combinational, one-hot grant.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the master that was not granted last wins.
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Arbitrates two MMIO masters onto one IO bus, one transaction per 4 cycles.
module mmio_bus_arbiter
    import mmio_pkg::*;
#(
    parameter int ADDR_W = MMIO_ADDR_W,
    parameter int DATA_W = MMIO_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_cs,
    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_cs,
    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              bus_cs,
    output logic              bus_wr,
    output logic              bus_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data
);

    arb_state_t        state_q, state_d;
    arb_op_t           op_q;
    logic              last_q;
    logic [1:0]        req, gnt;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bus_cs_q, bus_wr_q, bus_rd_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wr_data_q;
    logic              m0_ack_q, m1_ack_q;
    logic [DATA_W-1:0] m0_rd_data_q, m1_rd_data_q;

    assign req[0] = m0_cs & (m0_wr | m0_rd);
    assign req[1] = m1_cs & (m1_wr | m1_rd);

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    // Grant is one-hot, so an AND-OR mux selects the winner's request.
    assign sel_wr    = (gnt[0] & m0_wr) | (gnt[1] & m1_wr);
    assign sel_addr  = ({ADDR_W{gnt[0]}} & m0_addr)
                     | ({ADDR_W{gnt[1]}} & m1_addr);
    assign sel_wdata = ({DATA_W{gnt[0]}} & m0_wr_data)
                     | ({DATA_W{gnt[1]}} & m1_wr_data);

    assign rdata_d = (op_q == OP_RD) ? bus_rd_data : rdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            op_q          <= OP_RD;
            rdata_q       <= '0;
            bus_cs_q      <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_rd_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_rd_data_q  <= '0;
            m1_rd_data_q  <= '0;
        end else begin
            state_q  <= state_d;
            bus_cs_q <= 1'b0;
            bus_wr_q <= 1'b0;
            bus_rd_q <= 1'b0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        last_q        <= gnt[1];
                        op_q          <= sel_wr ? OP_WR : OP_RD;
                        bus_addr_q    <= sel_addr;
                        bus_wr_data_q <= sel_wdata;
                        bus_cs_q      <= 1'b1;
                        bus_wr_q      <= sel_wr;
                        bus_rd_q      <= ~sel_wr;
                    end
                end
                WAIT: begin
                    rdata_q <= rdata_d;
                    if (last_q) begin
                        m1_ack_q     <= 1'b1;
                        m1_rd_data_q <= rdata_d;
                    end else begin
                        m0_ack_q     <= 1'b1;
                        m0_rd_data_q <= rdata_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_cs      = bus_cs_q;
    assign bus_wr      = bus_wr_q;
    assign bus_rd      = bus_rd_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rd_data  = m0_rd_data_q;
    assign m1_rd_data  = m1_rd_data_q;

endmodule

// File: doc/mmio_bus_arbiter.md
MMIO_BUS_ARBITER -- requirements
Module: mmio_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL be the address width of every bus port.
REQ-002 Parameter DATA_W, default 32, SHALL be the data width of every bus port.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, on the ports named clk and reset.
REQ-004 clk  in  1  SHALL be the system clock; all state updates on the rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 m0_cs, m0_wr, m0_rd  in  1 each  SHALL be the master-0 (CPU) request, write and read strobes.
REQ-007 m0_addr  in  ADDR_W, m0_wr_data  in  DATA_W  SHALL be the master-0 address and write data.
REQ-008 m0_ack  out  1, m0_rd_data  out  DATA_W  SHALL be the master-0 completion pulse and read data.
REQ-009 Master-1 (debug/loader) SHALL have the identical port set with an m1_ prefix.
REQ-010 bus_cs, bus_wr, bus_rd  out  1 each  SHALL be the strobes to the IO subsystem.
REQ-011 bus_addr  out  ADDR_W, bus_wr_data  out  DATA_W  SHALL be the address and write data to the IO subsystem.
REQ-012 bus_rd_data  in  DATA_W  SHALL be the IO subsystem read data, valid the cycle after bus_rd.

Function
REQ-013 A master request SHALL be valid when mN_cs=1 and (mN_wr=1 or mN_rd=1); cs with neither strobe SHALL be ignored.
REQ-014 A request with wr=1 and rd=1 together SHALL be executed as a write only.
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE, with IDLE->ISSUE on any valid request and ISSUE->WAIT->DONE->IDLE unconditionally.
REQ-016 On the IDLE->ISSUE transition the block SHALL latch the winning master's id, addr, wr_data and op.
REQ-017 Arbitration SHALL be round-robin: with a single requester, that master SHALL be granted.
REQ-018 With both masters requesting, the master not granted last SHALL be granted.
REQ-019 last_grant SHALL update only on IDLE->ISSUE.
REQ-020 In ISSUE, bus_cs=1 and exactly one of bus_wr/bus_rd=1 SHALL be driven from the latched registers; all bus outputs SHALL come from registers.
REQ-021 Outside ISSUE, bus_cs, bus_wr and bus_rd SHALL be 0; bus_addr and bus_wr_data SHALL hold their last latched values.
REQ-022 In WAIT, for a read, bus_rd_data SHALL be captured into rdata_q; for a write, rdata_q SHALL be unchanged.
REQ-023 In DONE, only the granted master's ack SHALL be 1 for exactly one cycle, and its rd_data SHALL equal rdata_q.
REQ-024 mN_rd_data SHALL hold its value between acks and be ignored by masters on writes.
REQ-025 Latency SHALL be 4 cycles from request sampled in IDLE to ack (IDLE, ISSUE, WAIT, DONE), with sustained throughput of one transaction per 4 cycles.
REQ-026 A master SHALL hold cs/strobes/addr/data until ack; changes after latching SHALL NOT affect the transaction in flight.
REQ-027 A request still asserted in the cycle after its ack SHALL be treated as a new request.
REQ-028 A request deasserted before being sampled in IDLE SHALL be dropped with no ack.

Reset
REQ-029 Reset SHALL force state=IDLE and last_grant=1, so that m0 wins the first tie.
REQ-030 Reset SHALL clear bus_cs/wr/rd=0, bus_addr=0, bus_wr_data=0, rdata_q=0, m0_ack=m1_ack=0 and m0/m1_rd_data=0.
REQ-031 Reset asserted mid-transaction SHALL abort it: no ack issued, bus strobes 0 in the next cycle, and no partial strobe.

Structure
REQ-032 Package mmio_pkg SHALL hold the state enum arb_state_t (IDLE, ISSUE, WAIT, DONE), the op enum (OP_RD, OP_WR) and the default widths MMIO_ADDR_W=32 and MMIO_DATA_W=32.
REQ-033 Sub-module rr_pick2 SHALL be purely combinational, with inputs req[1:0] and last and outputs gnt[1:0] one-hot.
REQ-034 mmio_bus_arbiter SHALL instantiate rr_pick2 once.

Verification
REQ-035 Case m0 only: m0 write addr=0x0000_0010, data=0xA5A5_0001 -> bus_cs=bus_wr=1 for one cycle with that addr/data, and m0_ack 3 cycles after ISSUE; m1_ack stays 0.
REQ-036 Case m1 only: m1 read addr=0x0000_0004 with the slave returning 0xDEAD_BEEF in WAIT -> m1_ack=1 with m1_rd_data=0xDEAD_BEEF, and bus_rd high exactly one cycle.
REQ-037 Case tie: both masters request continuously after reset -> grant order m0, m1, m0, m1, with acks spaced 4 cycles.
REQ-038 Case both strobes: m0 with wr=rd=1, addr=0x8 -> bus_wr=1, bus_rd=0, and rdata_q unchanged.
REQ-039 Case abort: reset asserted during WAIT of an m0 read -> no m0_ack, all outputs at reset values next cycle, and after release m0 wins the next tie.
REQ-040 Case in-flight isolation: m0 changes addr from 0x10 to 0x20 during ISSUE -> bus_addr stays 0x10 for that transaction.
